data_mem_access_ctrl: RTL and testbench

//  Sequences MEM-stage loads and stores onto a single-outstanding req/ack data-memory bus.

---
 rtl/data_mem_access_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_data_mem_access_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_access_ctrl
// Brief    : MEM-stage load/store sequencer for a single-outstanding req/ack
//            data bus with strobes, load extraction and error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int           c_CNT_W       = $clog2(TIMEOUT_CYCLES);
    localparam [c_CNT_W-1:0] c_CNT_LAST    = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam [1:0]         c_ERR_OK      = 2'b00;
    localparam [1:0]         c_ERR_ALIGN   = 2'b01;
    localparam [1:0]         c_ERR_ILLEGAL = 2'b10;
    localparam [1:0]         c_ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_off;
    logic [2:0]         r_f3;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_issue;
    logic        w_fail;
    logic [1:0]  w_fail_code;
    logic        w_ack_done;
    logic        w_timeout;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_shifted;
    logic [31:0] w_extract;

    // A store wins when both controls are high, so legality follows mem_wr.
    always_comb begin
        w_illegal = 1'b1;
        if (mem_wr) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
                default:                w_illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
                default:                                w_illegal = 1'b1;
            endcase
        end
    end

    assign w_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                          ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        w_strb      = 4'b1111;
        w_wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_strb      = 4'b0001 << addr[1:0];
                w_wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_strb      = 4'b0011 << addr[1:0];
                w_wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                w_strb      = 4'b1111;
                w_wdata_rep = wdata;
            end
        endcase
    end

    assign w_shifted = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_extract = bus_rdata;
        case (r_f3)
            3'b000:  w_extract = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_extract = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_extract = {24'h0, w_shifted[7:0]};
            3'b101:  w_extract = {16'h0, w_shifted[15:0]};
            default: w_extract = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_fail       = 1'b0;
        w_fail_code  = c_ERR_OK;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_wr || mem_rd) begin
                    if (w_illegal) begin
                        w_fail       = 1'b1;
                        w_fail_code  = c_ERR_ILLEGAL;
                        w_next_state = S_DONE;
                    end else if (w_misaligned) begin
                        w_fail       = 1'b1;
                        w_fail_code  = c_ERR_ALIGN;
                        w_next_state = S_DONE;
                    end else begin
                        w_issue      = 1'b1;
                        w_next_state = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // An ack in the final allowed cycle still completes normally.
                if (bus_ack) begin
                    w_ack_done   = 1'b1;
                    w_next_state = S_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign stall = ((r_state == S_IDLE) && (mem_rd || mem_wr)) || (r_state == S_REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_strb  <= 4'h0;
            rdata     <= 32'h0;
            err       <= c_ERR_OK;
            done      <= 1'b0;
            r_cnt     <= '0;
            r_off     <= 2'b00;
            r_f3      <= 3'b000;
        end else begin
            done <= 1'b0;
            if (w_issue) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_wr;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_wdata <= w_wdata_rep;
                bus_strb  <= mem_wr ? w_strb : 4'b0000;
                r_off     <= addr[1:0];
                r_f3      <= funct3;
                r_cnt     <= '0;
            end
            if (r_state == S_REQ) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_fail) begin
                done <= 1'b1;
                err  <= w_fail_code;
            end
            if (w_ack_done) begin
                bus_req <= 1'b0;
                done    <= 1'b1;
                err     <= c_ERR_OK;
                if (!bus_we) begin
                    rdata <= w_extract;
                end
            end
            if (w_timeout) begin
                bus_req <= 1'b0;
                done    <= 1'b1;
                err     <= c_ERR_TIMEOUT;
                rdata   <= 32'h0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_access_ctrl
// Brief    : Directed self-checking bench for data_mem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    // Observations of the most recent access
    int          res_stall;
    int          res_done_cyc;
    int          res_req_cyc;
    logic        res_saw_req;
    logic [3:0]  res_strb;
    logic [31:0] res_addr;
    logic [31:0] res_wdata;
    logic        res_we;
    logic [1:0]  res_err;
    logic [31:0] res_rdata;

    data_mem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_strb  (bus_strb),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one instruction from an IDLE cycle (entered at posedge+1).
    // Cycle 1 is the cycle the instruction is presented; ack_delay is the
    // number of REQ cycles without ack before ack is raised (-1: never).
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ack_delay, input logic [31:0] brd);
        mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
        bus_ack = 1'b0; bus_rdata = brd;
        res_stall = 0; res_done_cyc = 0; res_req_cyc = 0; res_saw_req = 1'b0;
        res_strb = 4'hx; res_addr = 32'hx; res_wdata = 32'hx; res_we = 1'bx;
        res_err = 2'bxx; res_rdata = 32'hx;
        for (int cyc = 1; cyc <= 40 && res_done_cyc == 0; cyc++) begin
            #1;
            if (done === 1'b1) begin
                res_done_cyc = cyc;
                res_err      = err;
                res_rdata    = rdata;
            end
            if (stall === 1'b1) res_stall++;
            if (bus_req === 1'b1) begin
                res_saw_req = 1'b1;
                res_strb    = bus_strb;
                res_addr    = bus_addr;
                res_wdata   = bus_wdata;
                res_we      = bus_we;
                res_req_cyc++;
                bus_ack = (ack_delay >= 0) && (res_req_cyc > ack_delay);
            end else begin
                bus_ack = 1'b0;
            end
            if (res_done_cyc == 0) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus_req, bus_we, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got req/we/done=%b expected 000", {bus_req, bus_we, done});
        end
        tests_run++;
        if ({bus_addr, bus_wdata, bus_strb} !== 68'h0) begin
            tests_failed++;
            $display("FAIL reset_bus: got addr=%h wdata=%h strb=%b expected zeros", bus_addr, bus_wdata, bus_strb);
        end
        tests_run++;
        if (rdata !== 32'h0 || err !== 2'b00 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out: got rdata=%h err=%b stall=%b expected 0/00/0", rdata, err, stall);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stores();
        do_access(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h1234_56AB, 1, 32'h0);
        tests_run++;
        if (res_strb !== 4'b1000 || res_wdata !== 32'hABAB_ABAB || res_addr !== 32'h0000_1000 || res_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_bus: got strb=%b wdata=%h addr=%h we=%b expected 1000/ABABABAB/00001000/1",
                     res_strb, res_wdata, res_addr, res_we);
        end
        tests_run++;
        if (res_err !== 2'b00 || res_done_cyc != 4 || res_stall != 3) begin
            tests_failed++;
            $display("FAIL sb_timing: got err=%b done_cyc=%0d stall=%0d expected 00/4/3",
                     res_err, res_done_cyc, res_stall);
        end
        do_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h7777_BEEF, 0, 32'h0);
        tests_run++;
        if (res_strb !== 4'b1100 || res_wdata !== 32'hBEEF_BEEF || res_addr !== 32'h0000_2000) begin
            tests_failed++;
            $display("FAIL sh_bus: got strb=%b wdata=%h addr=%h expected 1100/BEEFBEEF/00002000",
                     res_strb, res_wdata, res_addr);
        end
        do_access(1'b0, 1'b1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 0, 32'h0);
        tests_run++;
        if (res_strb !== 4'b1111 || res_wdata !== 32'hDEAD_BEEF || res_err !== 2'b00) begin
            tests_failed++;
            $display("FAIL sw_bus: got strb=%b wdata=%h err=%b expected 1111/DEADBEEF/00",
                     res_strb, res_wdata, res_err);
        end
    endtask

    task automatic test_loads();
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 0, 32'h0000_80FF);
        tests_run++;
        if (res_rdata !== 32'hFFFF_FF80 || res_strb !== 4'b0000 || res_we !== 1'b0 || res_addr !== 32'h0000_2000) begin
            tests_failed++;
            $display("FAIL lb: got rdata=%h strb=%b we=%b addr=%h expected FFFFFF80/0000/0/00002000",
                     res_rdata, res_strb, res_we, res_addr);
        end
        tests_run++;
        if (res_done_cyc != 3 || res_stall != 2) begin
            tests_failed++;
            $display("FAIL load_latency: got done_cyc=%0d stall=%0d expected 3/2", res_done_cyc, res_stall);
        end
        do_access(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 0, 32'h0000_80FF);
        tests_run++;
        if (res_rdata !== 32'h0000_0080) begin
            tests_failed++;
            $display("FAIL lbu: got rdata=%h expected 00000080", res_rdata);
        end
        do_access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 2, 32'h8001_1234);
        tests_run++;
        if (res_rdata !== 32'hFFFF_8001 || res_done_cyc != 5) begin
            tests_failed++;
            $display("FAIL lh: got rdata=%h done_cyc=%0d expected FFFF8001/5", res_rdata, res_done_cyc);
        end
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 32'h8001_1234);
        tests_run++;
        if (res_rdata !== 32'h0000_8001) begin
            tests_failed++;
            $display("FAIL lhu: got rdata=%h expected 00008001", res_rdata);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'h0, 0, 32'h8001_1234);
        tests_run++;
        if (res_rdata !== 32'h8001_1234 || res_err !== 2'b00) begin
            tests_failed++;
            $display("FAIL lw: got rdata=%h err=%b expected 80011234/00", res_rdata, res_err);
        end
    endtask

    task automatic test_errors();
        do_access(1'b0, 1'b1, 3'b010, 32'h0000_3002, 32'h1111_2222, 0, 32'h0);
        tests_run++;
        if (res_saw_req !== 1'b0 || res_err !== 2'b01 || res_done_cyc != 2 || res_stall != 1) begin
            tests_failed++;
            $display("FAIL sw_misaligned: got req=%b err=%b done_cyc=%0d stall=%0d expected 0/01/2/1",
                     res_saw_req, res_err, res_done_cyc, res_stall);
        end
        tests_run++;
        if (res_rdata !== 32'h8001_1234) begin
            tests_failed++;
            $display("FAIL rdata_hold: got rdata=%h expected 80011234", res_rdata);
        end
        do_access(1'b1, 1'b0, 3'b101, 32'h0000_2001, 32'h0, 0, 32'h0);
        tests_run++;
        if (res_saw_req !== 1'b0 || res_err !== 2'b01) begin
            tests_failed++;
            $display("FAIL lhu_misaligned: got req=%b err=%b expected 0/01", res_saw_req, res_err);
        end
        do_access(1'b1, 1'b0, 3'b011, 32'h0000_2000, 32'h0, 0, 32'h0);
        tests_run++;
        if (res_saw_req !== 1'b0 || res_err !== 2'b10 || res_done_cyc != 2) begin
            tests_failed++;
            $display("FAIL load_illegal: got req=%b err=%b done_cyc=%0d expected 0/10/2",
                     res_saw_req, res_err, res_done_cyc);
        end
        // Both controls high with a load-only size: treated as an illegal store
        do_access(1'b1, 1'b1, 3'b100, 32'h0000_2000, 32'h0, 0, 32'h0);
        tests_run++;
        if (res_saw_req !== 1'b0 || res_err !== 2'b10) begin
            tests_failed++;
            $display("FAIL store_priority: got req=%b err=%b expected 0/10", res_saw_req, res_err);
        end
    endtask

    task automatic test_timeout();
        logic bad;
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, -1, 32'h5555_5555);
        tests_run++;
        if (res_req_cyc != 16 || res_err !== 2'b11 || res_rdata !== 32'h0 || res_done_cyc != 18) begin
            tests_failed++;
            $display("FAIL timeout: got req_cyc=%0d err=%b rdata=%h done_cyc=%0d expected 16/11/0/18",
                     res_req_cyc, res_err, res_rdata, res_done_cyc);
        end
        bad = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            if (bus_req !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) bad = 1'b1;
            @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        tests_run++;
        if (bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_ack: got disturbance=%b expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_req();
        mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h0000_4000; bus_ack = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (bus_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_req: got bus_req=%b expected 1", bus_req);
        end
        mem_rd = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus_req !== 1'b0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_req: got bus_req=%b stall=%b expected 0/0", bus_req, stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_no_done: got done=%b expected 0", done);
        end
        do_access(1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'h0, 0, 32'hCAFE_F00D);
        tests_run++;
        if (res_rdata !== 32'hCAFE_F00D || res_err !== 2'b00 || res_done_cyc != 3) begin
            tests_failed++;
            $display("FAIL rst_recover: got rdata=%h err=%b done_cyc=%0d expected CAFEF00D/00/3",
                     res_rdata, res_err, res_done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 3'b000, 32'h0000_6003, 32'h0, 0, 32'h7F00_0000);
        tests_run++;
        if (res_rdata !== 32'h0000_007F) begin
            tests_failed++;
            $display("FAIL b2b_first: got rdata=%h expected 0000007F", res_rdata);
        end
        do_access(1'b1, 1'b0, 3'b001, 32'h0000_6000, 32'h0, 0, 32'h0000_F00D);
        tests_run++;
        if (res_rdata !== 32'hFFFF_F00D || res_done_cyc != 3) begin
            tests_failed++;
            $display("FAIL b2b_second: got rdata=%h done_cyc=%0d expected FFFFF00D/3",
                     res_rdata, res_done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_errors();
        test_timeout();
        test_reset_mid_req();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
